mem_ctrl: RTL

- Sole arbiter between the core and the byte-wide unified RAM/IO bus.
- Serves two requesters:
  - instruction fetch: 64-byte cache-line reads that fill the I-cache;
  - load/store buffer (LSB): 1/2/4-byte loads and stores.
- Serialises each request into per-byte bus transactions, assembles or scatters the data, and returns a one-cycle done pulse.
- Sits directly downstream of the fetch stage and the LSB; directly upstream of the RAM.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared sizes, load/store length encodings, IO region tag and state encoding
// for the byte-wide RAM/IO bus controller.
package mem_ctrl_pkg;

    localparam int ADDR_WID        = 32;
    localparam int ICACHE_BLK_WID  = 512;
    localparam int ICACHE_BLK_SIZE = 64;

    localparam logic [2:0] LS_LEN_B = 3'd1;
    localparam logic [2:0] LS_LEN_H = 3'd2;
    localparam logic [2:0] LS_LEN_W = 3'd4;

    // addr[17:16] value that selects the UART/IO region
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IF_READ  = 2'd1,
        S_LS_READ  = 2'd2,
        S_LS_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter between instruction fetch and the load/store buffer on the byte-wide
// RAM/IO bus: serialises each request into byte transactions and pulses done.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int BLK_BYTES = ICACHE_BLK_SIZE,
    parameter int ADDR_W    = ADDR_WID
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic                      if_en,
    input  logic [ADDR_W-1:0]         if_pc,
    output logic                      if_done,
    output logic [ICACHE_BLK_WID-1:0] if_data,
    input  logic                      lsb_en,
    input  logic                      lsb_wr,
    input  logic [ADDR_W-1:0]         lsb_addr,
    input  logic [2:0]                lsb_len,
    input  logic [31:0]               lsb_wdata,
    output logic                      lsb_done,
    output logic [31:0]               lsb_rdata,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [ADDR_W-1:0]         mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full
);

    state_e                    r_state, w_state_nxt;
    logic [6:0]                r_cnt, w_cnt_nxt;
    logic [6:0]                r_len, w_len_nxt;
    logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
    logic [31:0]               r_wdata, w_wdata_nxt;
    logic [ADDR_W-1:0]         r_mem_a, w_mem_a_nxt;
    logic [7:0]                r_mem_dout, w_mem_dout_nxt;
    logic [ICACHE_BLK_WID-1:0] r_if_data, w_if_data_nxt;
    logic [31:0]               r_lsb_rdata, w_lsb_rdata_nxt;
    logic                      r_if_done, w_if_done_nxt;
    logic                      r_lsb_done, w_lsb_done_nxt;

    logic [6:0]        w_cnt_inc;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [6:0]        w_req_len;
    logic [5:0]        w_slot_blk;
    logic [1:0]        w_slot_word;
    logic              w_io_stall;

    // r_cnt counts bytes already addressed; the byte captured now belongs to slot r_cnt-1
    assign w_cnt_inc   = r_cnt + 7'd1;
    assign w_addr_inc  = r_addr + {{(ADDR_W-7){1'b0}}, w_cnt_inc};
    assign w_slot_blk  = r_cnt[5:0] - 6'd1;
    assign w_slot_word = r_cnt[1:0] - 2'd1;
    assign w_io_stall  = (r_state == S_LS_WRITE) && (r_addr[17:16] == IO_REGION) && io_buffer_full;

    // Decode the requested load/store length; unknown codes fall back to one byte
    always_comb begin
        case (lsb_len)
            LS_LEN_B: w_req_len = 7'd1;
            LS_LEN_H: w_req_len = 7'd2;
            LS_LEN_W: w_req_len = 7'd4;
            default:  w_req_len = 7'd1;
        endcase
    end

    // Next-state, byte sequencing and data assembly
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_mem_a_nxt     = r_mem_a;
        w_mem_dout_nxt  = r_mem_dout;
        w_if_data_nxt   = r_if_data;
        w_lsb_rdata_nxt = r_lsb_rdata;
        w_if_done_nxt   = 1'b0;
        w_lsb_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // a done pulse still visible means the requester has not dropped en yet
                if (!rollback && !r_if_done && !r_lsb_done && (lsb_en || if_en)) begin
                    w_cnt_nxt = 7'd0;
                    if (lsb_en) begin
                        w_addr_nxt  = lsb_addr;
                        w_mem_a_nxt = lsb_addr;
                        w_len_nxt   = w_req_len;
                        w_wdata_nxt = lsb_wdata;
                        if (lsb_wr) begin
                            w_state_nxt    = S_LS_WRITE;
                            w_mem_dout_nxt = lsb_wdata[7:0];
                        end else begin
                            w_state_nxt     = S_LS_READ;
                            w_lsb_rdata_nxt = 32'd0;
                        end
                    end else begin
                        w_addr_nxt  = if_pc;
                        w_mem_a_nxt = if_pc;
                        w_len_nxt   = 7'(BLK_BYTES);
                        w_state_nxt = S_IF_READ;
                    end
                end else begin
                    w_mem_a_nxt = {ADDR_W{1'b0}};
                end
            end
            S_IF_READ, S_LS_READ: begin
                if (rollback) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 7'd0;
                    w_mem_a_nxt = {ADDR_W{1'b0}};
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_mem_a_nxt = (w_cnt_inc < r_len) ? w_addr_inc : {ADDR_W{1'b0}};
                    if (r_cnt != 7'd0) begin
                        if (r_state == S_IF_READ) begin
                            w_if_data_nxt[{w_slot_blk, 3'b000} +: 8] = mem_din;
                        end else begin
                            w_lsb_rdata_nxt[{w_slot_word, 3'b000} +: 8] = mem_din;
                        end
                    end else begin
                        w_if_data_nxt = r_if_data;
                    end
                    if (r_cnt == r_len) begin
                        w_state_nxt    = S_IDLE;
                        w_cnt_nxt      = 7'd0;
                        w_if_done_nxt  = (r_state == S_IF_READ);
                        w_lsb_done_nxt = (r_state == S_LS_READ);
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
            end
            S_LS_WRITE: begin
                // stores ignore rollback: once committed they always complete
                if (w_io_stall) begin
                    w_cnt_nxt = r_cnt;
                end else if (w_cnt_inc < r_len) begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_mem_a_nxt    = w_addr_inc;
                    w_mem_dout_nxt = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_cnt_nxt      = 7'd0;
                    w_mem_a_nxt    = {ADDR_W{1'b0}};
                    w_mem_dout_nxt = 8'd0;
                    w_lsb_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 7'd0;
                w_mem_a_nxt = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_len       <= 7'd0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= 32'd0;
            r_mem_a     <= {ADDR_W{1'b0}};
            r_mem_dout  <= 8'd0;
            r_if_data   <= {ICACHE_BLK_WID{1'b0}};
            r_lsb_rdata <= 32'd0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_mem_a     <= w_mem_a_nxt;
            r_mem_dout  <= w_mem_dout_nxt;
            r_if_data   <= w_if_data_nxt;
            r_lsb_rdata <= w_lsb_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_lsb_done  <= w_lsb_done_nxt;
        end
    end

    assign mem_wr    = (r_state == S_LS_WRITE) && rdy && !w_io_stall;
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign lsb_done  = r_lsb_done;
    assign lsb_rdata = r_lsb_rdata;

endmodule
